count_nest_yi: RTL and testbench
================================

Name: count_nest_yi

Overview:
- Parametrised successor of the single-level start/final counter.
- Chains LEVELS counter stages into one loop nest, for tile/row/channel address generation in the conv datapath.
- Each level has its own start, final and step; a level advances only when all inner levels wrap.
- Adds per-level last flags, a synchronous clear, and a one-shot mode with a sticky done flag.

Parameters:
- LEVELS, 3, number of nested levels; level 0 is innermost; legal 1..8.
- BITS_OF_END_NUMBER, 10, width of every per-level value, start, final and step.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  advance the nest by one innermost step this cycle; low = stall.
- clear  input  1  synchronous restart: all counters to 0 and done to 0.
- mode  input  1  0 = wrap (free-running nest); 1 = one-shot (stop after the full nest).
- start_number  input  LEVELS*BITS_OF_END_NUMBER  per-level start value, level i at bits [i*B +: B].
- final_number  input  LEVELS*BITS_OF_END_NUMBER  per-level final value, same packing.
- step_number  input  LEVELS*BITS_OF_END_NUMBER  per-level increment, same packing; 0 is treated as 1.
- total_q  output  LEVELS*BITS_OF_END_NUMBER  per-level current value, start_i + cnt_i, same packing.
- last  output  LEVELS  per-level wrap strobe (combinational).
- all_last  output  1  equals last[LEVELS-1]; the whole nest completes this cycle.
- done  output  1  one-shot completion flag (registered, sticky).

Behaviour:
- State per level: internal offset register cnt_i. total_q_i = start_i + cnt_i, mod 2^B. Configuration inputs must be held stable while counting.
- Reset: all cnt_i = 0 and done = 0, so total_q = start_number. last = 0 and all_last = 0 while enable is 0.
- Combinational signals:
  - at_final_i = (total_q_i >= final_i), unsigned compare.
  - adv = enable & ~clear & ~done.
  - carry_0 = adv; carry_{i+1} = carry_i & at_final_i.
  - last_i = carry_i & at_final_i, so last outputs are already gated by adv.
- Update on clock edge, per level:
  - if clear: cnt_i <= 0.
  - else if carry_i & at_final_i: cnt_i <= 0 (wrap).
  - else if carry_i: cnt_i <= cnt_i + eff_step_i, where eff_step_i = (step_i == 0) ? 1 : step_i, B-bit wrap-around.
  - else: hold.
- Overshoot: a value may pass final when the step does not divide (final - start). It still wraps on the next advance, because the compare is >=.
- start_i > final_i: at_final_i is true at once, so level i wraps on every carry-in and its value stays at start_i.
- Mode 0 (wrap): after all_last, every level returns to start and counting continues; done stays 0.
- Mode 1 (one-shot):
  - on the all_last cycle, counters wrap to 0 and done <= 1 at the next edge.
  - while done = 1, enable is ignored, counters hold, and last/all_last are forced 0.
  - done clears only on clear or reset.
- Mode changed mid-run: takes effect at the next all_last. Setting mode = 0 while done = 1 does not clear done.
- clear and enable in the same cycle: clear wins; no advance, no last strobes.
- Reset mid-operation: asynchronous return to the reset state on assertion. Counting resumes on the first enabled edge after deassertion.
- Latency:
  - total_q changes on the clock edge after an enabled cycle.
  - last/all_last are valid in the same cycle as the enabled advance that wraps.
  - done rises one edge after all_last.
- LEVELS = 1 reproduces the single-level counter, plus step, clear and one-shot.

Test Plan:
- Nest sequence: LEVELS=2, B=4, start={0,0}, final={1,2}, step={1,1}, mode=0, enable held. (L1,L0) goes (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(0,0). last[0] is high on cycles 3 and 6. last[1]/all_last is high only on cycle 6.
- Step and overshoot: LEVELS=1, start=3, final=9. Step 3 gives 3,6,9,3 with last on the 9. Step 4 gives 3,7,11,3 with last on the 11. Step 0 gives 3,4,5,...
- Stall: the same nest as the first scenario with enable toggled 1,0,0,1. Values hold during the low cycles, last stays 0 while enable = 0, and no step is skipped or duplicated.
- One-shot: the first-scenario nest with mode=1. After all_last at (1,2), done=1 at the next edge, total_q={0,0}, and values stay frozen with enable=1. A clear pulse gives done=0, and counting restarts at (0,0).
- Clear priority and reset: clear=1 with enable=1 at (1,1) gives (0,0) next cycle with no last. Asserting reset mid-count immediately gives total_q = start_number and done = 0.

Source files
------------

// File: rtl/count_nest_yi_if.sv
// Control, configuration and status bundle for count_nest_yi.
// master: drives enable/clear/mode/config; slave: drives total_q/last/all_last/done.
interface count_nest_yi_if #(
  parameter int LEVELS             = 3,
  parameter int BITS_OF_END_NUMBER = 10
);
  localparam int W = LEVELS * BITS_OF_END_NUMBER;

  logic          enable;
  logic          clear;
  logic          mode;
  logic [W-1:0]  start_number;
  logic [W-1:0]  final_number;
  logic [W-1:0]  step_number;
  logic [W-1:0]  total_q;
  logic [LEVELS-1:0] last;
  logic          all_last;
  logic          done;

  modport master (
    output enable, clear, mode,
    output start_number, final_number, step_number,
    input  total_q, last, all_last, done
  );

  modport slave (
    input  enable, clear, mode,
    input  start_number, final_number, step_number,
    output total_q, last, all_last, done
  );
endinterface

// File: rtl/count_nest_yi.sv
// Nested start/final/step counter (level 0 innermost) with one-shot done.
// Ports: clk, reset (async, active-high), bus (slave side of count_nest_yi_if).
module count_nest_yi #(
  parameter int LEVELS             = 3,
  parameter int BITS_OF_END_NUMBER = 10
) (
  input  logic           clk,
  input  logic           reset,
  count_nest_yi_if.slave bus
);
  localparam int B = BITS_OF_END_NUMBER;

  logic [LEVELS-1:0][B-1:0] cnt_q;
  logic [LEVELS-1:0][B-1:0] cnt_d;
  logic [LEVELS-1:0][B-1:0] tot;
  logic [LEVELS-1:0]        at_final;
  logic [LEVELS-1:0]        last_w;
  logic [LEVELS:0]          carry;
  logic                     done_q;
  logic                     done_d;

  always_comb begin
    logic [B-1:0] st;
    logic [B-1:0] fin;
    logic [B-1:0] eff;
    cnt_d    = cnt_q;
    tot      = '0;
    at_final = '0;
    last_w   = '0;
    carry    = '0;
    st       = '0;
    fin      = '0;
    eff      = '0;
    carry[0] = bus.enable & ~bus.clear & ~done_q;
    for (int i = 0; i < LEVELS; i++) begin
      st          = bus.start_number[i*B +: B];
      fin         = bus.final_number[i*B +: B];
      eff         = (bus.step_number[i*B +: B] == '0) ?
                    {{(B-1){1'b0}}, 1'b1} :
                    bus.step_number[i*B +: B];
      tot[i]      = st + cnt_q[i];
      // >= so an overshooting step still wraps on the next advance
      at_final[i] = (tot[i] >= fin);
      last_w[i]   = carry[i] & at_final[i];
      carry[i+1]  = last_w[i];
      if (bus.clear)
        cnt_d[i] = '0;
      else if (last_w[i])
        cnt_d[i] = '0;
      else if (carry[i])
        cnt_d[i] = cnt_q[i] + eff;
    end
  end

  // carry out of the outermost level is the whole-nest completion
  always_comb begin
    done_d = done_q;
    if (bus.clear)
      done_d = 1'b0;
    else if (carry[LEVELS] & bus.mode)
      done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.total_q  = tot;
  assign bus.last     = last_w;
  assign bus.all_last = carry[LEVELS];
  assign bus.done     = done_q;
endmodule

// File: tb/tb_count_nest_yi.sv
// Directed bench for count_nest_yi: 2-level nest and 1-level step cases.
// Expected values are hand-computed tables.
module tb_count_nest_yi;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  count_nest_yi_if #(.LEVELS(2), .BITS_OF_END_NUMBER(4)) b2 ();
  count_nest_yi_if #(.LEVELS(1), .BITS_OF_END_NUMBER(4)) b1 ();

  count_nest_yi #(.LEVELS(2), .BITS_OF_END_NUMBER(4)) u2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  count_nest_yi #(.LEVELS(1), .BITS_OF_END_NUMBER(4)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s1_t [7] = '{8'h00, 8'h01, 8'h02, 8'h10,
                           8'h11, 8'h12, 8'h00};
  logic [1:0] s1_l [7] = '{2'd0, 2'd0, 2'd1, 2'd0,
                           2'd0, 2'd3, 2'd0};

  logic       st_e [7] = '{1'b1, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b1};
  logic [7:0] st_t [7] = '{8'h00, 8'h01, 8'h01, 8'h01,
                           8'h02, 8'h10, 8'h10};
  logic [1:0] st_l [7] = '{2'd0, 2'd0, 2'd0, 2'd0,
                           2'd1, 2'd0, 2'd0};

  logic [3:0] p1_s [3]    = '{4'd3, 4'd4, 4'd0};
  logic [3:0] p1_t [3][4] = '{'{4'd3, 4'd6, 4'd9,  4'd3},
                              '{4'd3, 4'd7, 4'd11, 4'd3},
                              '{4'd3, 4'd4, 4'd5,  4'd6}};
  logic       p1_l [3][4] = '{'{1'b0, 1'b0, 1'b1, 1'b0},
                              '{1'b0, 1'b0, 1'b1, 1'b0},
                              '{1'b0, 1'b0, 1'b0, 1'b0}};

  initial begin
    reset           = 1'b1;
    b2.enable       = 1'b0;
    b2.clear        = 1'b0;
    b2.mode         = 1'b0;
    b2.start_number = 8'h00;
    b2.final_number = 8'h12;
    b2.step_number  = 8'h11;
    b1.enable       = 1'b0;
    b1.clear        = 1'b0;
    b1.mode         = 1'b0;
    b1.start_number = 4'd3;
    b1.final_number = 4'd9;
    b1.step_number  = 4'd3;
    repeat (2) nxt();
    chk("rst_total", 32'(b2.total_q), 32'h00);
    chk("rst_done", 32'(b2.done), 32'h0);
    chk("rst_last", 32'(b2.last), 32'h0);
    chk("rst_total1", 32'(b1.total_q), 32'h3);
    reset = 1'b0;
    nxt();

    // free-running nest
    b2.enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("nest_t%0d", k), 32'(b2.total_q), 32'(s1_t[k]));
      chk($sformatf("nest_l%0d", k), 32'(b2.last), 32'(s1_l[k]));
      chk($sformatf("nest_a%0d", k), 32'(b2.all_last),
          32'(s1_l[k][1]));
      nxt();
    end

    // stall pattern from a cleared nest
    b2.enable = 1'b0;
    b2.clear  = 1'b1;
    nxt();
    b2.clear = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b2.enable = st_e[k];
      #1;
      chk($sformatf("stall_t%0d", k), 32'(b2.total_q), 32'(st_t[k]));
      chk($sformatf("stall_l%0d", k), 32'(b2.last), 32'(st_l[k]));
      nxt();
    end
    chk("stall_end", 32'(b2.total_q), 32'h11);

    // clear beats enable
    b2.enable = 1'b1;
    b2.clear  = 1'b1;
    #1;
    chk("clr_last", 32'(b2.last), 32'h0);
    nxt();
    b2.clear = 1'b0;
    b2.enable = 1'b0;
    chk("clr_total", 32'(b2.total_q), 32'h00);

    // one-shot
    b2.mode   = 1'b1;
    b2.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("os_t%0d", k), 32'(b2.total_q), 32'(s1_t[k]));
      chk($sformatf("os_a%0d", k), 32'(b2.all_last),
          32'(s1_l[k][1]));
      chk($sformatf("os_d%0d", k), 32'(b2.done), 32'h0);
      nxt();
    end
    chk("os_done", 32'(b2.done), 32'h1);
    chk("os_zero", 32'(b2.total_q), 32'h00);
    b2.mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("os_frz_l", 32'(b2.last), 32'h0);
      chk("os_frz_a", 32'(b2.all_last), 32'h0);
      nxt();
      chk("os_frz_t", 32'(b2.total_q), 32'h00);
      chk("os_frz_d", 32'(b2.done), 32'h1);
    end
    b2.enable = 1'b0;
    b2.clear  = 1'b1;
    nxt();
    b2.clear = 1'b0;
    chk("os_clr_d", 32'(b2.done), 32'h0);
    chk("os_clr_t", 32'(b2.total_q), 32'h00);
    b2.enable = 1'b1;
    nxt();
    nxt();
    chk("os_restart", 32'(b2.total_q), 32'h02);

    // asynchronous reset mid-count
    #2;
    reset = 1'b1;
    #1;
    chk("arst_total", 32'(b2.total_q), 32'h00);
    chk("arst_done", 32'(b2.done), 32'h0);
    b2.enable = 1'b0;
    nxt();
    reset = 1'b0;
    nxt();

    // single level: step, overshoot, zero step
    for (int r = 0; r < 3; r++) begin
      b1.step_number = p1_s[r];
      b1.enable      = 1'b1;
      b1.clear       = 1'b1;
      nxt();
      b1.clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        chk($sformatf("s%0d_t%0d", r, k), 32'(b1.total_q),
            32'(p1_t[r][k]));
        chk($sformatf("s%0d_l%0d", r, k), 32'(b1.last),
            32'(p1_l[r][k]));
        nxt();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
